// File: rtl/column_bypass_divider.sv
// column_bypass_divider: sequential 32-bit unsigned divider.
// A leading-one detect on the dividend means that only its significant bits are iterated.
// Zero dividend, zero divisor and dividend < divisor complete without iterating.
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   start_i              request, sampled only in IDLE
//   op_a_i / op_b_i      dividend / divisor
//   rem_sel_i            0 = quotient, 1 = remainder (captured with start)
//   rd_idx_i             destination register index (captured with start)
//   busy_o               high while iterating
//   done_o               one-cycle completion pulse
//   result_o             quotient or remainder, held until the next completion
//   result_rd_idx_o      rd index of the completed op, held until the next completion
module column_bypass_divider (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        rem_sel_i,
    input  logic [4:0]  rd_idx_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [4:0]  result_rd_idx_o
);

    localparam int unsigned W  = 32;
    localparam int unsigned KW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    rem_q;
    logic            rem_sel_q;
    logic [4:0]      rd_q;
    logic [KW-1:0]   k_q;

    logic [KW-1:0]   lod_idx_d;
    logic [W:0]      rem_shift_d;
    logic            rem_ge_d;
    logic [W-1:0]    rem_d;

    // Leading-one detect on the incoming dividend; the highest set bit wins.
    always_comb begin
        lod_idx_d = '0;
        for (int i = 0; i < W; i++) begin
            if (op_a_i[i]) begin
                lod_idx_d = KW'(i);
            end
        end
    end

    // One restoring-division step. The 33-bit shift keeps the carry-out of the
    // partial remainder visible to the compare.
    always_comb begin
        rem_shift_d = {rem_q, a_q[k_q]};
        rem_ge_d    = (rem_shift_d >= {1'b0, b_q});
        rem_d       = rem_ge_d ? W'(rem_shift_d - {1'b0, b_q}) : W'(rem_shift_d);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            a_q             <= '0;
            b_q             <= '0;
            quo_q           <= '0;
            rem_q           <= '0;
            rem_sel_q       <= 1'b0;
            rd_q            <= '0;
            k_q             <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            result_o        <= '0;
            result_rd_idx_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_o <= 1'b0;
                    if (start_i) begin
                        a_q       <= op_a_i;
                        b_q       <= op_b_i;
                        rem_sel_q <= rem_sel_i;
                        rd_q      <= rd_idx_i;
                        quo_q     <= '0;
                        rem_q     <= '0;
                        k_q       <= '0;
                        if (op_b_i == '0) begin
                            quo_q   <= '1;
                            rem_q   <= op_a_i;
                            state_q <= S_DONE;
                        end else if (op_a_i == '0) begin
                            state_q <= S_DONE;
                        end else if (op_a_i < op_b_i) begin
                            rem_q   <= op_a_i;
                            state_q <= S_DONE;
                        end else begin
                            k_q     <= lod_idx_d;
                            busy_o  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    quo_q[k_q] <= rem_ge_d;
                    rem_q      <= rem_d;
                    if (k_q == '0) begin
                        busy_o  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        k_q <= k_q - KW'(1);
                    end
                end
                S_DONE: begin
                    result_o        <= rem_sel_q ? rem_q : quo_q;
                    result_rd_idx_o <= rd_q;
                    done_o          <= 1'b1;
                    state_q         <= S_IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_column_bypass_divider.sv
// Testbench for column_bypass_divider: directed cases, then randomised operands
// compared against a plain-arithmetic reference model.
module tb_column_bypass_divider;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        rem_sel_i;
    logic [4:0]  rd_idx_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  result_rd_idx_o;

    int n_vec = 0;
    int n_err = 0;

    column_bypass_divider dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .op_a_i          (op_a_i),
        .op_b_i          (op_b_i),
        .rem_sel_i       (rem_sel_i),
        .rd_idx_i        (rd_idx_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .result_o        (result_o),
        .result_rd_idx_o (result_rd_idx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int msb_of(input logic [31:0] v);
        int m = -1;
        for (int i = 0; i < 32; i++) if (v[i]) m = i;
        return m;
    endfunction

    // Runs one op and checks result, rd, latency and busy length against the model.
    // sync=0 launches straight away (used to start in the done_o cycle).
    // poke=1 pulses start_i with other operands while the op is iterating.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic rs,
                          input logic [4:0] rd, input bit sync, input bit poke);
        logic [31:0] exp_q, exp_r, exp_res;
        bit          bypass;
        int          exp_lat, exp_busy, cyc, bc;
        bit          seen;
        exp_q    = (b == 0) ? 32'hFFFF_FFFF : a / b;
        exp_r    = (b == 0) ? a : a % b;
        exp_res  = rs ? exp_r : exp_q;
        bypass   = (b == 0) || (a == 0) || (a < b);
        exp_lat  = bypass ? 2 : msb_of(a) + 3;
        exp_busy = bypass ? 0 : msb_of(a) + 1;
        if (sync) @(negedge clk_i);
        op_a_i = a; op_b_i = b; rem_sel_i = rs; rd_idx_i = rd; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc  = 1;
        bc   = busy_o ? 1 : 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            if (done_o) begin
                seen = 1'b1;
            end else begin
                @(posedge clk_i); #1;
                cyc++;
                if (poke && cyc == 3) begin
                    start_i = 1'b1; op_a_i = 32'd77; op_b_i = 32'd5;
                    rem_sel_i = ~rs; rd_idx_i = ~rd;
                end else begin
                    start_i = 1'b0;
                end
                if (busy_o) bc++;
            end
        end
        check("done_seen", 64'(seen), 64'(1));
        check("latency", 64'(cyc), 64'(exp_lat));
        check("busy_cycles", 64'(bc), 64'(exp_busy));
        check("result", 64'(result_o), 64'(exp_res));
        check("rd_idx", 64'(result_rd_idx_o), 64'(rd));
    endtask

    // After a completion: done_o must drop and result_o must hold.
    task automatic check_pulse_end(input logic [31:0] held);
        @(posedge clk_i); #1;
        check("done_single_pulse", 64'(done_o), 64'(0));
        check("result_held", 64'(result_o), 64'(held));
    endtask

    initial begin
        logic [31:0] a, b;
        logic [31:0] held;
        bit          stray;
        int          mode;
        rst_i = 1'b1; start_i = 1'b0; op_a_i = '0; op_b_i = '0;
        rem_sel_i = 1'b0; rd_idx_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_busy", 64'(busy_o), 64'(0));
        check("reset_done", 64'(done_o), 64'(0));
        check("reset_result", 64'(result_o), 64'(0));
        check("reset_rd", 64'(result_rd_idx_o), 64'(0));
        @(negedge clk_i); rst_i = 1'b0;

        // Basic iterating cases
        run_op(32'd100, 32'd7, 1'b0, 5'd5, 1'b1, 1'b0);
        check_pulse_end(32'd14);
        run_op(32'd100, 32'd7, 1'b1, 5'd5, 1'b1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 5'd31, 1'b1, 1'b0);
        check_pulse_end(32'hFFFF_FFFF);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 5'd1, 1'b1, 1'b0);

        // Bypass cases
        run_op(32'h1234, 32'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        run_op(32'h1234, 32'd0, 1'b1, 5'd3, 1'b1, 1'b0);
        run_op(32'd0, 32'd9, 1'b0, 5'd4, 1'b1, 1'b0);
        run_op(32'd0, 32'd9, 1'b1, 5'd6, 1'b1, 1'b0);
        run_op(32'd3, 32'd10, 1'b0, 5'd7, 1'b1, 1'b0);
        run_op(32'd3, 32'd10, 1'b1, 5'd8, 1'b1, 1'b0);

        // start_i during RUN is ignored; a start in the done_o cycle is accepted
        run_op(32'd1000, 32'd3, 1'b0, 5'd9, 1'b1, 1'b1);
        run_op(32'd1000, 32'd3, 1'b1, 5'd10, 1'b0, 1'b0);
        run_op(32'd81, 32'd9, 1'b0, 5'd11, 1'b0, 1'b0);
        check_pulse_end(32'd9);

        // Asynchronous reset mid-RUN
        @(negedge clk_i);
        op_a_i = 32'hFFFF_FFFF; op_b_i = 32'd1; rem_sel_i = 1'b0; rd_idx_i = 5'd12;
        start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_result", 64'(result_o), 64'(0));
        check("rst_rd", 64'(result_rd_idx_o), 64'(0));
        @(negedge clk_i); rst_i = 1'b0;
        stray = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) stray = 1'b1;
        end
        check("no_done_after_reset", 64'(stray), 64'(0));
        run_op(32'd81, 32'd9, 1'b0, 5'd13, 1'b1, 1'b0);

        // Randomised operands, biased towards short dividends and corner divisors
        for (int n = 0; n < 1500; n++) begin
            mode = int'($urandom_range(0, 7));
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            case (mode)
                0: b = 32'd1;
                1: b = a;
                2: b = 32'd0;
                3: b = b >> 24;
                4: a = 32'd0;
                default: ;
            endcase
            run_op(a, b, 1'($urandom), 5'($urandom), 1'($urandom), 1'b0);
        end

        held = result_o;
        check_pulse_end(held);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
